frame_scheduler_tx: RTL and testbench
=====================================

// Module: frame_scheduler_tx
// PURPOSE
//  Sequences the 66b TX block stream: chooses START/DATA/TERM/IDLE for every block slot and
//  reserves one alignment-marker (AM) slot per period. Packet requests are accepted with
//  a block count, and a minimum inter-packet idle gap is enforced. Drives the frame-type
//  select of the frame builder and the AM inserter, between the MAC-side request logic and the encoder.
// PARAMETERS
//  AM_BLOCK_PERIOD  16383                     frame slots between AM slots (AM slot is extra)
//  NB_AM_CNT        $clog2(AM_BLOCK_PERIOD+1) width of AM period counter
//  NB_LEN           10                        width of packet length (DATA blocks per packet)
//  MIN_IDLE         2                         min IDLE blocks between TERM and next START (>=1)
//  NB_IDLE_CNT      $clog2(MIN_IDLE+1)        width of saturating idle counter
// PORTS
//  i_clock        in   1          block clock
//  i_reset_n      in   1          asynchronous active-low reset
//  i_enable       in   1          global enable; 0 freezes all state
//  i_valid        in   1          block-slot strobe; tick = i_enable & i_valid
//  i_pkt_req      in   1          packet pending (level, held until o_pkt_ack)
//  i_pkt_len      in   NB_LEN     DATA blocks in pending packet (0 allowed)
//  o_pkt_ack      out  1          1-cycle pulse: request consumed, START issued
//  o_frame_type   out  2          START=0 DATA=1 TERM=2 IDLE=3
//  o_frame_valid  out  1          o_frame_type is a new block this cycle
//  o_am_slot      out  1          1-cycle pulse: this slot carries an AM, no frame
//  o_in_packet    out  1          1 from START through TERM inclusive
// BEHAVIOUR
//  - Reset: o_frame_type=IDLE, o_frame_valid=0, o_am_slot=0, o_pkt_ack=0, o_in_packet=0;
//    state S_IDLE, am_cnt=0, idle_cnt=0, data_cnt=0.
//  - All outputs are registered and updated on the tick edge (latency 1 from the tick).
//    Non-tick cycles: frame_valid/am_slot/ack=0, type and in_packet hold, all state holds.
//  - AM: on a tick with am_cnt==AM_BLOCK_PERIOD, o_am_slot=1, o_frame_valid=0, am_cnt->0,
//    FSM and data/idle counters hold. Any other tick: am_cnt+1, o_frame_valid=1, FSM steps.
//    AM slots may fall inside a packet; the packet resumes on the next tick.
//  - FSM (frame ticks only):
//    S_IDLE: if i_pkt_req && idle_cnt>=MIN_IDLE -> emit START, pulse ack, latch len,
//            data_cnt=0, next = (len==0) ? S_TERM : S_DATA; else emit IDLE, idle_cnt sat+1.
//    S_DATA: emit DATA, data_cnt+1; when data_cnt==len_q-1 -> S_TERM.
//    S_TERM: emit TERM, idle_cnt=0 -> S_IDLE.
//  - i_pkt_req/i_pkt_len are sampled only at the S_IDLE decision; changes mid-packet are
//    ignored. A request dropped before ack is never started.
//  - idle_cnt saturates at MIN_IDLE. data_cnt is NB_LEN wide and never wraps (exits at len-1).
//  - Async reset mid-packet aborts the packet: no TERM, outputs go straight to reset values.
//  - i_enable=0 with i_valid=1 is not a tick (no AM count, no frame).
// STRUCTURE
//  - Shared include frame_types.vh: FT_START/FT_DATA/FT_TERM/FT_IDLE 2-bit codes,
//    66b sync headers and type bytes (also used by the frame builder and decoder).
//  - Sub-module am_period_counter (AM_BLOCK_PERIOD, NB_AM_CNT): tick in, am_slot out,
//    wraps at AM_BLOCK_PERIOD. The FSM, counters and output registers sit in this module.
// TESTING (AM_BLOCK_PERIOD=8, MIN_IDLE=2, i_valid=1, i_enable=1 unless noted)
//  1 req=1,len=3 from reset: ticks t0..t7 = IDLE,IDLE,START(ack),DATA,DATA,DATA,TERM,IDLE;
//    t8 am_slot=1 frame_valid=0; t9 IDLE; t10 START (gap of 2 IDLEs straddling the AM).
//  2 len=0: START then TERM directly, no DATA, in_packet=1 for exactly those 2 frames.
//  3 len=6 with START at t2: AM at t8 falls in DATA run; 6 DATA total, TERM at t10.
//  4 i_valid toggles 1,0 each cycle: frame sequence identical to scenario 1 on tick cycles;
//    non-tick cycles have frame_valid=0, am_slot=0, type held.
//  5 i_reset_n low during DATA: all outputs go to reset values at once; after release,
//    2 IDLEs precede the next START; am_cnt restarts from 0.
//  6 req=1, then len changed to 9 mid-packet: the packet still carries 3 DATA blocks;
//    req dropped before the S_IDLE decision -> no START, IDLE continues.

Source files
------------

// File: rtl/frame_scheduler_tx_pkg.sv
// rtl/frame_scheduler_tx_pkg.sv - shared frame codes and scheduler state encoding
// Frame-type codes are shared with the frame builder and decoder. The 66b sync
// headers and block type bytes sit here so that every block uses the same values.
package frame_scheduler_tx_pkg;

    typedef enum logic [1:0] {
        FT_START = 2'd0,
        FT_DATA  = 2'd1,
        FT_TERM  = 2'd2,
        FT_IDLE  = 2'd3
    } frame_type_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_TERM = 2'd2
    } sched_state_e;

    // 66b sync headers
    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    // Control block type bytes
    localparam logic [7:0] BT_START = 8'h78;
    localparam logic [7:0] BT_TERM0 = 8'h87;
    localparam logic [7:0] BT_IDLE  = 8'h1E;

endpackage

// File: rtl/frame_scheduler_tx_am_period_counter.sv
// rtl/frame_scheduler_tx_am_period_counter.sv - alignment-marker period counter
// Counts block-slot ticks. o_am_due is high while the count sits at
// AM_BLOCK_PERIOD: the tick taken in that state is the AM slot, and the count
// wraps to 0 on it, so a full period is AM_BLOCK_PERIOD frames plus one AM slot.
// Ports:
//   i_clock, i_reset_n : block clock, asynchronous active-low reset
//   i_tick             : a block slot is consumed this cycle
//   o_am_due           : the next tick is the AM slot
module am_period_counter #(
    parameter int AM_BLOCK_PERIOD = 16383,
    parameter int NB_AM_CNT       = $clog2(AM_BLOCK_PERIOD + 1)
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_tick,
    output logic o_am_due
);

    logic [NB_AM_CNT-1:0] am_cnt_q;

    assign o_am_due = (am_cnt_q == NB_AM_CNT'(AM_BLOCK_PERIOD));

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            am_cnt_q <= '0;
        end else if (i_tick) begin
            if (o_am_due) begin
                am_cnt_q <= '0;
            end else begin
                am_cnt_q <= am_cnt_q + NB_AM_CNT'(1);
            end
        end
    end

endmodule

// File: rtl/frame_scheduler_tx.sv
// rtl/frame_scheduler_tx.sv - 66b TX block slot scheduler
// Picks START/DATA/TERM/IDLE for every block slot, reserves one AM slot per
// period and enforces a minimum idle gap between TERM and the next START.
// All outputs are registered and change only on a tick (i_enable & i_valid).
// Ports:
//   i_clock, i_reset_n   : block clock, asynchronous active-low reset
//   i_enable, i_valid    : tick qualifiers
//   i_pkt_req, i_pkt_len : pending packet request (level) and DATA block count
//   o_pkt_ack            : request consumed, START issued this slot
//   o_frame_type         : frame code of the current slot
//   o_frame_valid        : o_frame_type is a new block
//   o_am_slot            : this slot carries an alignment marker
//   o_in_packet          : high from START through TERM
module frame_scheduler_tx
    import frame_scheduler_tx_pkg::*;
#(
    parameter int AM_BLOCK_PERIOD = 16383,
    parameter int NB_AM_CNT       = $clog2(AM_BLOCK_PERIOD + 1),
    parameter int NB_LEN          = 10,
    parameter int MIN_IDLE        = 2,
    parameter int NB_IDLE_CNT     = $clog2(MIN_IDLE + 1)
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_enable,
    input  logic              i_valid,
    input  logic              i_pkt_req,
    input  logic [NB_LEN-1:0] i_pkt_len,
    output logic              o_pkt_ack,
    output logic [1:0]        o_frame_type,
    output logic              o_frame_valid,
    output logic              o_am_slot,
    output logic              o_in_packet
);

    logic tick;
    logic am_due;

    sched_state_e           state_q;
    frame_type_e            frame_type_q;
    logic                   frame_valid_q;
    logic                   am_slot_q;
    logic                   ack_q;
    logic                   in_packet_q;
    logic [NB_LEN-1:0]      len_q;
    logic [NB_LEN-1:0]      data_cnt_q;
    logic [NB_IDLE_CNT-1:0] idle_cnt_q;

    assign tick = i_enable & i_valid;

    am_period_counter #(
        .AM_BLOCK_PERIOD (AM_BLOCK_PERIOD),
        .NB_AM_CNT       (NB_AM_CNT)
    ) u_am_cnt (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_tick    (tick),
        .o_am_due  (am_due)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= S_IDLE;
            frame_type_q  <= FT_IDLE;
            frame_valid_q <= 1'b0;
            am_slot_q     <= 1'b0;
            ack_q         <= 1'b0;
            in_packet_q   <= 1'b0;
            len_q         <= '0;
            data_cnt_q    <= '0;
            idle_cnt_q    <= '0;
        end else begin
            // Pulses default low; type and in_packet hold outside frame slots.
            frame_valid_q <= 1'b0;
            am_slot_q     <= 1'b0;
            ack_q         <= 1'b0;
            if (tick) begin
                if (am_due) begin
                    // AM slot steals the tick; the packet/idle sequence resumes next tick.
                    am_slot_q <= 1'b1;
                end else begin
                    frame_valid_q <= 1'b1;
                    case (state_q)
                        S_IDLE: begin
                            if (i_pkt_req && (idle_cnt_q >= NB_IDLE_CNT'(MIN_IDLE))) begin
                                frame_type_q <= FT_START;
                                ack_q        <= 1'b1;
                                in_packet_q  <= 1'b1;
                                len_q        <= i_pkt_len;
                                data_cnt_q   <= '0;
                                state_q      <= (i_pkt_len == '0) ? S_TERM : S_DATA;
                            end else begin
                                frame_type_q <= FT_IDLE;
                                in_packet_q  <= 1'b0;
                                if (idle_cnt_q < NB_IDLE_CNT'(MIN_IDLE)) begin
                                    idle_cnt_q <= idle_cnt_q + NB_IDLE_CNT'(1);
                                end
                            end
                        end
                        S_DATA: begin
                            frame_type_q <= FT_DATA;
                            in_packet_q  <= 1'b1;
                            data_cnt_q   <= data_cnt_q + NB_LEN'(1);
                            // len_q is non-zero here, so len_q-1 cannot underflow.
                            if (data_cnt_q == len_q - NB_LEN'(1)) begin
                                state_q <= S_TERM;
                            end
                        end
                        S_TERM: begin
                            frame_type_q <= FT_TERM;
                            in_packet_q  <= 1'b1;
                            idle_cnt_q   <= '0;
                            state_q      <= S_IDLE;
                        end
                        default: begin
                            frame_type_q <= FT_IDLE;
                            in_packet_q  <= 1'b0;
                            state_q      <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign o_pkt_ack     = ack_q;
    assign o_frame_type  = frame_type_q;
    assign o_frame_valid = frame_valid_q;
    assign o_am_slot     = am_slot_q;
    assign o_in_packet   = in_packet_q;

endmodule

// File: tb/tb_frame_scheduler_tx.sv
// tb/tb_frame_scheduler_tx.sv - scoreboard bench for frame_scheduler_tx
module tb_frame_scheduler_tx;

    localparam int P  = 8;
    localparam int MI = 2;
    localparam int NL = 10;

    localparam logic [1:0] T_START = 2'd0;
    localparam logic [1:0] T_DATA  = 2'd1;
    localparam logic [1:0] T_TERM  = 2'd2;
    localparam logic [1:0] T_IDLE  = 2'd3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en    = 1'b0;
    logic          vld   = 1'b0;
    logic          req   = 1'b0;
    logic [NL-1:0] len   = '0;
    logic          ack;
    logic [1:0]    ft;
    logic          fv;
    logic          am;
    logic          inp;

    frame_scheduler_tx #(
        .AM_BLOCK_PERIOD (P),
        .NB_LEN          (NL),
        .MIN_IDLE        (MI)
    ) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_enable      (en),
        .i_valid       (vld),
        .i_pkt_req     (req),
        .i_pkt_len     (len),
        .o_pkt_ack     (ack),
        .o_frame_type  (ft),
        .o_frame_valid (fv),
        .o_am_slot     (am),
        .o_in_packet   (inp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       am;
        logic [1:0] ft;
        logic       ack;
        logic       inp;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  checks = 0;
    int  passes = 0;

    // Reference model: slot position within the AM period, a list of frames
    // still owed by the current packet, and idles seen since the last TERM.
    int         m_ticks;
    int         m_idles;
    logic [1:0] m_pend[$];
    logic [1:0] m_last_ft;
    logic       m_inp;
    logic       m_acked;
    logic [1:0] mon_ft;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, expv, $time);
    endtask

    function automatic void model_reset();
        m_ticks   = 0;
        m_idles   = 0;
        m_pend.delete();
        m_last_ft = T_IDLE;
        m_inp     = 1'b0;
        m_acked   = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void model_tick(input logic r, input logic [NL-1:0] l);
        ev_t e;
        e.am  = ((m_ticks % (P + 1)) == P);
        e.ack = 1'b0;
        m_ticks++;
        m_acked = 1'b0;
        if (e.am) begin
            e.ft  = m_last_ft;
            e.inp = m_inp;
        end else if (m_pend.size() > 0) begin
            e.ft  = m_pend.pop_front();
            e.inp = 1'b1;
            if (e.ft == T_TERM) m_idles = 0;
        end else if (r && m_idles >= MI) begin
            e.ft    = T_START;
            e.ack   = 1'b1;
            e.inp   = 1'b1;
            m_acked = 1'b1;
            for (int i = 0; i < int'(l); i++) m_pend.push_back(T_DATA);
            m_pend.push_back(T_TERM);
        end else begin
            e.ft  = T_IDLE;
            e.inp = 1'b0;
            m_idles++;
        end
        m_last_ft = e.ft;
        m_inp     = e.inp;
        exp_q.push_back(e);
    endfunction

    // Monitor: compares whatever the DUT presents against the scoreboard.
    always @(negedge clk) begin
        ev_t e;
        ev_t o;
        if (rst_n) begin
            if (fv || am) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_slot", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("am_slot", int'(am), int'(e.am));
                    chk("frame_valid", int'(fv), int'(!e.am));
                    chk("frame_type", int'(ft), int'(e.ft));
                    chk("pkt_ack", int'(ack), int'(e.ack));
                    chk("in_packet", int'(inp), int'(e.inp));
                    mon_ft = e.ft;
                end
                o.am  = am;
                o.ft  = ft;
                o.ack = ack;
                o.inp = inp;
                obs_q.push_back(o);
            end else begin
                chk("hold_type", int'(ft), int'(mon_ft));
                chk("hold_ack", int'(ack), 0);
                if (exp_q.size() != 0) begin
                    chk("missing_slot", exp_q.size(), 0);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic e, input logic v, input logic r, input logic [NL-1:0] l);
        @(negedge clk);
        #1;
        en  = e;
        vld = v;
        req = r;
        len = l;
        if (e && v && rst_n) model_tick(r, l);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        en    = 1'b0;
        vld   = 1'b0;
        model_reset();
        obs_q.delete();
        mon_ft = T_IDLE;
        #1;
        chk("rst_frame_type", int'(ft), int'(T_IDLE));
        chk("rst_frame_valid", int'(fv), 0);
        chk("rst_am_slot", int'(am), 0);
        chk("rst_pkt_ack", int'(ack), 0);
        chk("rst_in_packet", int'(inp), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [1:0] s1_types [0:10];

    initial begin
        s1_types[0] = T_IDLE;  s1_types[1] = T_IDLE;  s1_types[2]  = T_START;
        s1_types[3] = T_DATA;  s1_types[4] = T_DATA;  s1_types[5]  = T_DATA;
        s1_types[6] = T_TERM;  s1_types[7] = T_IDLE;  s1_types[8]  = T_IDLE;
        s1_types[9] = T_IDLE;  s1_types[10] = T_START;

        model_reset();
        mon_ft = T_IDLE;
        do_reset();

        // Scenario 1: len=3 from reset, compared against fixed slot sequence.
        for (int i = 0; i < 11; i++) drive(1'b1, 1'b1, 1'b1, 10'd3);
        drive(1'b0, 1'b1, 1'b0, 10'd3);
        chk("s1_slots", obs_q.size(), 11);
        if (obs_q.size() == 11) begin
            for (int i = 0; i < 11; i++) begin
                if (i == 8) chk("s1_am_at_t8", int'(obs_q[i].am), 1);
                else chk("s1_type", int'(obs_q[i].ft), int'(s1_types[i]));
            end
            chk("s1_ack_t2", int'(obs_q[2].ack), 1);
        end
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0, 10'd0);

        // Scenario 2: len=0.
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 10'd0);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, 10'd0);

        // Scenario 3: len=6, AM inside the DATA run.
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 10'd6);
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, 1'b0, 10'd6);

        // Scenario 4: valid toggling.
        do_reset();
        for (int i = 0; i < 24; i++) drive(1'b1, (i % 2) == 0, 1'b1, 10'd3);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 10'd3);

        // Scenario 5: reset during DATA, then gap and AM restart.
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, 10'd6);
        do_reset();
        for (int i = 0; i < 14; i++) drive(1'b1, 1'b1, 1'b1, 10'd2);

        // Scenario 6: len changed mid-packet, then request dropped before decision.
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 10'd3);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, 10'd9);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 10'd9);

        // Randomized traffic.
        do_reset();
        begin
            logic          r = 1'b0;
            logic [NL-1:0] l = '0;
            for (int i = 0; i < 4000; i++) begin
                if (m_acked && ($urandom % 4 != 0)) r = 1'b0;
                else if (r && ($urandom % 40 == 0)) r = 1'b0;
                else if (!r && ($urandom % 3 == 0)) begin
                    r = 1'b1;
                    l = ($urandom % 8 == 0) ? NL'($urandom_range(0, 20)) : NL'($urandom_range(0, 5));
                end else if ($urandom % 10 == 0) begin
                    l = NL'($urandom_range(0, 12));
                end
                if ($urandom % 1500 == 0) do_reset();
                drive(($urandom % 10) != 0, ($urandom % 5) != 0, r, l);
            end
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, '0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
